// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity unit: FSM state encoding and DATA_BITS limits.
package serial_parity_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StCheck = ST_CHECK,
    StDone  = ST_DONE
  } state_e;

  localparam int unsigned DATA_BITS_MIN = 1;
  localparam int unsigned DATA_BITS_MAX = 64;

  // Clamp a requested frame length into the legal range.
  function automatic int unsigned clamp_data_bits(input int unsigned n);
    if (n < DATA_BITS_MIN) return DATA_BITS_MIN;
    if (n > DATA_BITS_MAX) return DATA_BITS_MAX;
    return n;
  endfunction

endpackage

// File: rtl/serial_parity_unit_if.sv
// Serial bit stream in, framed parity results out; master drives bits, slave is the unit.
interface serial_parity_unit_if;

  logic start;
  logic bit_in;
  logic bit_valid;
  logic busy;
  logic parity_out;
  logic frame_done;
  logic parity_err;

  modport master (
    output start,
    output bit_in,
    output bit_valid,
    input  busy,
    input  parity_out,
    input  frame_done,
    input  parity_err
  );

  modport slave (
    input  start,
    input  bit_in,
    input  bit_valid,
    output busy,
    output parity_out,
    output frame_done,
    output parity_err
  );

endinterface

// File: rtl/decoder_xor_xnor.sv
// Two-input XOR/XNOR built from a 2-to-4 decoder: each output ORs the matching minterms.
module decoder_xor_xnor (
  input  logic a,
  input  logic b,
  output logic xor_g,
  output logic xnor_g
);

  logic [3:0] dec;

  always_comb begin
    dec = 4'b0000;
    dec[{a, b}] = 1'b1;
  end

  assign xor_g  = dec[1] | dec[2];
  assign xnor_g = dec[0] | dec[3];

endmodule

// File: rtl/serial_parity_unit.sv
// Framed serial parity generator; define SERIAL_PARITY_CHECK_EN to also consume and check
// a received parity bit after the data bits.
module serial_parity_unit
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_parity_unit_if.slave bus
);

  localparam int unsigned DataBits = clamp_data_bits(DATA_BITS);
  localparam int unsigned CntW     = $clog2(DataBits + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(DataBits - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            par_q, par_d;
  logic            pout_q, pout_d;
  logic            done_q, done_d;
  logic            busy_q;
  logic            xor_g;
  logic            xnor_unused;

  decoder_xor_xnor u_gate (
    .a      (par_q),
    .b      (bus.bit_in),
    .xor_g  (xor_g),
    .xnor_g (xnor_unused)
  );

`ifdef SERIAL_PARITY_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    pout_d  = pout_q;
    done_d  = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        // bit_valid is deliberately ignored here, even alongside start.
        if (bus.start) begin
          state_d = StShift;
          cnt_d   = '0;
          par_d   = ODD_PARITY;
          pout_d  = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        if (bus.bit_valid) begin
          par_d = xor_g;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
`ifdef SERIAL_PARITY_CHECK_EN
            state_d = StCheck;
`else
            state_d = StDone;
            pout_d  = xor_g;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef SERIAL_PARITY_CHECK_EN
      StCheck: begin
        if (bus.bit_valid) begin
          err_d   = (bus.bit_in != par_q);
          pout_d  = par_q;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      pout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      pout_q  <= pout_d;
      done_q  <= done_d;
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef SERIAL_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.parity_err = err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.busy       = busy_q;
  assign bus.parity_out = pout_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// Scoreboard bench: stimulus pushes expected {parity_out, parity_err}, a monitor pops on frame_done.
module tb_serial_parity_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_parity_unit_if if0 ();
  serial_parity_unit_if if1 ();

  serial_parity_unit #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  serial_parity_unit #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

`ifdef SERIAL_PARITY_CHECK_EN
  localparam int Latency = 10;
  localparam bit CheckEn = 1'b1;
`else
  localparam int Latency = 9;
  localparam bit CheckEn = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc0 = 0;
  int done_cyc0 = -100;
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic b, input logic v);
    if (sel) begin
      if1.start = s; if1.bit_in = b; if1.bit_valid = v;
    end else begin
      if0.start = s; if0.bit_in = b; if0.bit_valid = v;
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? if1.busy : if0.busy;
  endfunction

  // Monitor: pops one expected result per frame_done pulse.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (if0.frame_done === 1'b1) begin
        done_cyc0 = cyc;
        if (q0.size() == 0) chk("even_unexpected_done", 1, 0);
        else begin
          e = q0.pop_front();
          chk("even_parity_out", {31'd0, if0.parity_out}, {31'd0, e[1]});
          chk("even_parity_err", {31'd0, if0.parity_err}, {31'd0, e[0]});
          chk("even_busy_in_done", {31'd0, if0.busy}, 1);
        end
      end
      if (if1.frame_done === 1'b1) begin
        if (q1.size() == 0) chk("odd_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          chk("odd_parity_out", {31'd0, if1.parity_out}, {31'd0, e[1]});
          chk("odd_parity_err", {31'd0, if1.parity_err}, {31'd0, e[0]});
        end
      end
    end
  end

  // Start is driven with bit_valid=1 so an IDLE-accepted bit would corrupt the parity.
  // Returns on the DONE-cycle negedge so the next call starts back-to-back.
  task automatic send(input bit sel, input logic [7:0] data, input logic pbit, input int gap,
                      input int start_mid, input logic exp_p, input logic exp_e);
    logic [1:0] e;
    e = {exp_p, exp_e & CheckEn};
    @(negedge clk);
    drive(sel, 1'b1, 1'b1, 1'b1);
    if (sel) q1.push_back(e);
    else begin
      q0.push_back(e);
      start_cyc0 = cyc;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", {31'd0, busy_of(sel)}, 1);
      drive(sel, (i == start_mid), data[i], 1'b1);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          drive(sel, 1'b0, 1'b1, 1'b0);
          chk("busy_in_gap", {31'd0, busy_of(sel)}, 1);
        end
      end
    end
    if (CheckEn) begin
      @(negedge clk);
      drive(sel, 1'b0, pbit, 1'b1);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_busy", {31'd0, if0.busy}, 0);
    chk("rst_parity_out", {31'd0, if0.parity_out}, 0);
    chk("rst_frame_done", {31'd0, if0.frame_done}, 0);
    chk("rst_parity_err", {31'd0, if0.parity_err}, 0);
    chk("rst_odd_busy", {31'd0, if1.busy}, 0);
    chk("rst_odd_parity_out", {31'd0, if1.parity_out}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xB2: four ones -> even parity 0; check latency from start to frame_done.
    done_cyc0 = -100;
    send(0, 8'hB2, 1'b0, 0, -1, 1'b0, 1'b0);
    #1;
    chk("latency", done_cyc0 - start_cyc0, Latency);
    // 0xB3: five ones -> 1, correct parity bit, then wrong parity bit.
    send(0, 8'hB3, 1'b1, 0, -1, 1'b1, 1'b0);
    send(0, 8'hB3, 1'b0, 0, -1, 1'b1, 1'b1);
    // Gapped stream, same result.
    send(0, 8'hB3, 1'b1, 3, -1, 1'b1, 1'b0);
    // Start pulsed alongside bit 4 must be ignored.
    send(0, 8'hB2, 1'b0, 0, 4, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);

    // Odd parity unit.
    send(1, 8'h00, 1'b1, 0, -1, 1'b1, 1'b0);
    send(1, 8'h01, 1'b0, 0, -1, 1'b0, 1'b0);
    send(1, 8'h01, 1'b1, 0, -1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0);

    // Reset after 5 bits of a frame aborts it with no frame_done.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, if0.busy}, 0);
    chk("abort_parity_out", {31'd0, if0.parity_out}, 0);
    chk("abort_frame_done", {31'd0, if0.frame_done}, 0);
    chk("abort_parity_err", {31'd0, if0.parity_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'hB2, 1'b0, 0, -1, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("even_frames_missing", q0.size(), 0);
    chk("odd_frames_missing", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_parity_unit.md
# serial_parity_unit

Serial parity generator/checker that consumes one data bit per accepted cycle and folds it into a running parity through the codebase's decoder-based XOR gate. It sits downstream of the decoder XOR/XNOR stage, turning that combinational gate into a framed, clocked parity function. A frame is `DATA_BITS` serial bits, LSB first, plus an optional received parity bit. Results are held at the output until the next frame starts.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; legal range 1..64.
- `ODD_PARITY`, 0: 0 = even parity, 1 = odd parity; seeds the running parity.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request to begin a frame; honoured only when idle.
- `bit_in`  input  1  serial data or parity bit.
- `bit_valid`  input  1  `bit_in` is valid this cycle.
- `busy`  output  1  high whenever state is not IDLE.
- `parity_out`  output  1  computed parity of the last completed frame.
- `frame_done`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  received parity bit mismatched the computed parity.

## Operation
- State machine: IDLE, SHIFT, CHECK, DONE.
- **IDLE**
  - On `start=1`: go to SHIFT, clear `cnt`, load `par_q` with `ODD_PARITY`, clear `parity_out` and `parity_err`.
  - `bit_valid` is ignored, including a `bit_valid` in the same cycle as `start`.
- **SHIFT**, each cycle with `bit_valid=1`:
  - `par_q` takes the gate's `xor_g` output, with `a=par_q` and `b=bit_in`.
  - `cnt` increments.
  - On accepting the bit where `cnt==DATA_BITS-1`: go to CHECK if the macro is defined, otherwise go to DONE.
  - Cycles with `bit_valid=0` hold all state. Gaps of any length are legal.
- **CHECK**: on `bit_valid=1`, set `parity_err` to (`bit_in != par_q`) and go to DONE.
- **DONE**:
  - Lasts exactly one cycle, with `frame_done=1`.
  - `parity_out` was loaded from `par_q` on the entering edge.
  - Next state is IDLE unconditionally.
- `start` is ignored in SHIFT, CHECK and DONE.
- `bit_valid` is ignored in DONE.
- `cnt` width is `$clog2(DATA_BITS+1)`. It never wraps, because it is cleared at each start.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `busy=0`, `parity_out=0`, `frame_done=0`, `parity_err=0`, `cnt=0`, `par_q=0`.
- `rst_n` asserted mid-frame aborts the frame immediately. No `frame_done` is generated and the outputs return to their reset values.
- `busy` rises on the clock edge after `start` is sampled in IDLE.
- Latency: `frame_done` is high in the cycle after the edge that accepts the last bit. The last bit is the final data bit, or the parity bit when the macro is defined.
- `parity_out` and `parity_err` are valid from the `frame_done` cycle. They hold until the edge that accepts the next `start`.
- Minimum frame length in cycles: `1 + DATA_BITS (+1 with macro) + 1`. A back-to-back `start` is accepted in the cycle after DONE.

## Configuration
- Macro: `SERIAL_PARITY_CHECK_EN`.
- **Defined**
  - The CHECK state exists.
  - The frame consumes one extra received parity bit.
  - `parity_err` reports a mismatch.
- **Undefined**
  - Generate-only: the FSM goes SHIFT -> DONE.
  - `parity_err` is tied 0.
  - The port list is unchanged.

## Structure
- Shared package `serial_parity_pkg` holds:
  - state encoding constants `ST_IDLE=2'd0`, `ST_SHIFT=2'd1`, `ST_CHECK=2'd2`, `ST_DONE=2'd3`;
  - the `DATA_BITS` legal-range limits.
- One sub-module: an instance of the existing `decoder_xor_xnor` gate.
  - Inputs: `a=par_q`, `b=bit_in`.
  - Outputs: `xor_g` feeds `par_q`; `xnor_g` is left unused.
- The FSM, counter and output registers are in the top module.

## Test plan
- **Even parity, macro undefined**, `DATA_BITS=8`, `ODD_PARITY=0`:
  - Bits 0,1,0,0,1,1,0,1 (0xB2) sent back-to-back -> `frame_done` pulses once, 9 cycles after `start` is sampled, with `parity_out=0`.
  - Same setup with 0xB3 -> `parity_out=1`.
- **Odd parity**, `ODD_PARITY=1`: frame 0x00 -> `parity_out=1`. Frame 0x01 -> `parity_out=0`.
- **Gapped input**: 0xB3 with `bit_valid` low for 3 cycles between each pair of bits -> same result (`parity_out=1`). `busy` stays high throughout and `frame_done` is a single pulse.
- **Check mode**, macro defined:
  - 0xB3 followed by parity bit 1 -> `parity_err=0`.
  - 0xB3 followed by parity bit 0 -> `parity_err=1`, `parity_out=1`.
- **`start` while busy**: `start` pulsed during bit 4 of a frame -> ignored; the frame completes normally after 8 bits.
- **Reset mid-frame**: `rst_n` asserted after 5 bits:
  - Immediately -> `busy=0`, all outputs 0, no `frame_done`.
  - After release and a new `start`, the 0xB2 frame gives `parity_out=0`.
